// File: rtl/abs_diff_err_sweep.sv
// Exhaustive error-evaluation sweep for an approximate |a-b| circuit.
// Walks every {a,b} pair through the external DUT and accumulates the error count,
// the saturating summed error distance, and the worst-case error with its operands.
module abs_diff_err_sweep #(
    parameter int unsigned OP_W  = 4,
    parameter int unsigned RES_W = 4,
    parameter int unsigned SUM_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [OP_W-1:0]     op_a,
    output logic [OP_W-1:0]     op_b,
    input  logic [RES_W-1:0]    approx_res,
    output logic                busy,
    output logic                done,
    output logic [2*OP_W:0]     err_count,
    output logic [SUM_W-1:0]    err_sum,
    output logic                err_sat,
    output logic [OP_W-1:0]     err_max,
    output logic [OP_W-1:0]     wc_a,
    output logic [OP_W-1:0]     wc_b
);

    localparam int unsigned IdxW = 2 * OP_W;
    localparam logic [IdxW-1:0] LastIdx = '1;

    typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            clear;

    // Stage 1 pipeline registers
    logic             s1_valid_q;
    logic [OP_W-1:0]  s1_a_q, s1_b_q;
    logic [RES_W-1:0] s1_r_q;

    // Stage 2 accumulators
    logic [2*OP_W:0]  err_count_q, err_count_d;
    logic [SUM_W-1:0] err_sum_q, err_sum_d;
    logic             err_sat_q, err_sat_d;
    logic [OP_W-1:0]  err_max_q, err_max_d;
    logic [OP_W-1:0]  wc_a_q, wc_a_d;
    logic [OP_W-1:0]  wc_b_q, wc_b_d;

    logic [OP_W-1:0]  exact, approx_ext, ed;
    logic [SUM_W:0]   sum_ext;

    // Sequencer next state: start is only honoured in IDLE/DONE and clears the accumulators.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        clear   = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StSweep;
                    idx_d   = '0;
                    clear   = 1'b1;
                end
            end
            StSweep: begin
                if (idx_q == LastIdx) begin
                    state_d = StDrain;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            // Last vector is in stage 1 here; stage 2 retires it at the end of this cycle.
            StDrain: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    // Sequencer state and vector index; op_a/op_b hold the last vector until restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Stage 1: capture the applied operands together with the DUT's combinational result.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_r_q     <= '0;
        end else begin
            s1_valid_q <= (state_q == StSweep);
            s1_a_q     <= op_a;
            s1_b_q     <= op_b;
            s1_r_q     <= approx_res;
        end
    end

    // Stage 2 next state: error distance, saturating sum, and first-occurrence worst case.
    always_comb begin
        exact       = (s1_a_q > s1_b_q) ? (s1_a_q - s1_b_q) : (s1_b_q - s1_a_q);
        approx_ext  = OP_W'(s1_r_q);
        ed          = (exact > approx_ext) ? (exact - approx_ext) : (approx_ext - exact);
        sum_ext     = {1'b0, err_sum_q} + (SUM_W + 1)'(ed);
        err_count_d = err_count_q;
        err_sum_d   = err_sum_q;
        err_sat_d   = err_sat_q;
        err_max_d   = err_max_q;
        wc_a_d      = wc_a_q;
        wc_b_d      = wc_b_q;
        if (s1_valid_q) begin
            if (ed != '0) begin
                err_count_d = err_count_q + (2 * OP_W + 1)'(1);
            end
            if (sum_ext[SUM_W]) begin
                err_sum_d = '1;
                err_sat_d = 1'b1;
            end else begin
                err_sum_d = sum_ext[SUM_W-1:0];
            end
            // Strictly greater so ties keep the earliest pair in sweep order.
            if (ed > err_max_q) begin
                err_max_d = ed;
                wc_a_d    = s1_a_q;
                wc_b_d    = s1_b_q;
            end
        end
    end

    // Stage 2 accumulator registers; cleared on reset and on sweep entry.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            err_count_q <= '0;
            err_sum_q   <= '0;
            err_sat_q   <= 1'b0;
            err_max_q   <= '0;
            wc_a_q      <= '0;
            wc_b_q      <= '0;
        end else begin
            err_count_q <= err_count_d;
            err_sum_q   <= err_sum_d;
            err_sat_q   <= err_sat_d;
            err_max_q   <= err_max_d;
            wc_a_q      <= wc_a_d;
            wc_b_q      <= wc_b_d;
        end
    end

    assign {op_a, op_b} = idx_q;
    assign busy         = (state_q == StSweep) || (state_q == StDrain);
    assign done         = (state_q == StDone);
    assign err_count    = err_count_q;
    assign err_sum      = err_sum_q;
    assign err_sat      = err_sat_q;
    assign err_max      = err_max_q;
    assign wc_a         = wc_a_q;
    assign wc_b         = wc_b_q;

endmodule

// File: tb/tb_abs_diff_err_sweep.sv
// Bench for abs_diff_err_sweep: two instances (SUM_W=16 and SUM_W=8) share one stimulus,
// each driven by a behavioural approximate-|a-b| model; results are compared with totals
// computed directly from the pair-wise error rules.
module tb_abs_diff_err_sweep;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    int         mode;
    logic [3:0] lut [256];

    logic [3:0] op_a, op_b, approx, err_max, wc_a, wc_b;
    logic       busy, done, err_sat;
    logic [8:0] err_count;
    logic [15:0] err_sum;

    logic [3:0] op_a8, op_b8, approx8, err_max8, wc_a8, wc_b8;
    logic       busy8, done8, err_sat8;
    logic [8:0] err_count8;
    logic [7:0] err_sum8;

    int total = 0;
    int bad   = 0;

    int e_cnt, e_sum, e_max, e_wa, e_wb;

    always #5 clk = ~clk;

    abs_diff_err_sweep #(.OP_W(4), .RES_W(4), .SUM_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .approx_res(approx), .busy(busy), .done(done), .err_count(err_count),
        .err_sum(err_sum), .err_sat(err_sat), .err_max(err_max), .wc_a(wc_a), .wc_b(wc_b)
    );

    abs_diff_err_sweep #(.OP_W(4), .RES_W(4), .SUM_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a8), .op_b(op_b8),
        .approx_res(approx8), .busy(busy8), .done(done8), .err_count(err_count8),
        .err_sum(err_sum8), .err_sat(err_sat8), .err_max(err_max8), .wc_a(wc_a8),
        .wc_b(wc_b8)
    );

    function automatic int approx_of(input int m, input int a, input int b, input int lv);
        case (m)
            0:       return (a > b) ? a - b : b - a;
            1:       return 0;
            2:       return 15;
            default: return lv;
        endcase
    endfunction

    always_comb begin
        approx  = 4'(approx_of(mode, int'(op_a), int'(op_b), int'(lut[{op_a, op_b}])));
        approx8 = 4'(approx_of(mode, int'(op_a8), int'(op_b8), int'(lut[{op_a8, op_b8}])));
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: walk all pairs in sweep order and apply the error rules directly.
    task automatic compute_ref();
        int ex, ap, ed;
        e_cnt = 0; e_sum = 0; e_max = 0; e_wa = 0; e_wb = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                ex = (a > b) ? a - b : b - a;
                ap = approx_of(mode, a, b, int'(lut[a*16 + b]));
                ed = (ex > ap) ? ex - ap : ap - ex;
                if (ed != 0) e_cnt++;
                e_sum += ed;
                if (ed > e_max) begin
                    e_max = ed; e_wa = a; e_wb = b;
                end
            end
        end
    endtask

    task automatic check_results(input string tag);
        compute_ref();
        check_eq({tag, ".count"}, int'(err_count), e_cnt);
        check_eq({tag, ".sum"}, int'(err_sum), (e_sum > 65535) ? 65535 : e_sum);
        check_eq({tag, ".sat"}, int'(err_sat), (e_sum > 65535) ? 1 : 0);
        check_eq({tag, ".max"}, int'(err_max), e_max);
        check_eq({tag, ".wc_a"}, int'(wc_a), e_wa);
        check_eq({tag, ".wc_b"}, int'(wc_b), e_wb);
        check_eq({tag, ".count8"}, int'(err_count8), e_cnt);
        check_eq({tag, ".sum8"}, int'(err_sum8), (e_sum > 255) ? 255 : e_sum);
        check_eq({tag, ".sat8"}, int'(err_sat8), (e_sum > 255) ? 1 : 0);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, ".op"}, int'({op_a, op_b}), 0);
        check_eq({tag, ".busy"}, int'(busy), 0);
        check_eq({tag, ".done"}, int'(done), 0);
        check_eq({tag, ".count"}, int'(err_count), 0);
        check_eq({tag, ".sum"}, int'(err_sum), 0);
        check_eq({tag, ".sat"}, int'(err_sat), 0);
        check_eq({tag, ".max"}, int'(err_max), 0);
        check_eq({tag, ".wc"}, int'({wc_a, wc_b}), 0);
    endtask

    // Pulse start (sampled at the end of cycle t) and follow the sweep cycle by cycle.
    task automatic run_sweep(input int abort_at, input bit pulse_mid);
        int cyc;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cyc = 1;
        while (cyc < 400) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 1) begin
                check_eq("c1.busy", int'(busy), 1);
                check_eq("c1.done", int'(done), 0);
                check_eq("c1.count", int'(err_count), 0);
                check_eq("c1.max", int'(err_max), 0);
            end
            if (cyc <= 256) check_eq("vector", int'({op_a, op_b}), cyc - 1);
            if (cyc == 257) begin
                check_eq("c257.busy", int'(busy), 1);
                check_eq("c257.done", int'(done), 0);
            end
            if (pulse_mid && (cyc == 50 || cyc == 257)) start = 1'b1;
            if (cyc == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                check_zero("abort");
                return;
            end
            if (done) break;
            @(posedge clk);
            cyc++;
        end
        check_eq("done_latency", cyc, 258);
        check_eq("done8", int'(done8), 1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 0;
        foreach (lut[i]) lut[i] = 4'($urandom_range(0, 15));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        mode = 0; run_sweep(0, 1'b0); check_results("exact");
        mode = 1; run_sweep(0, 1'b0); check_results("stuck0");
        mode = 2; run_sweep(0, 1'b0); check_results("stuck15");
        mode = 3; run_sweep(0, 1'b0); check_results("rand1");
        foreach (lut[i]) lut[i] = 4'($urandom_range(0, 15));
        run_sweep(0, 1'b0); check_results("rand2");

        mode = 1; run_sweep(100, 1'b0);
        run_sweep(0, 1'b0); check_results("after_abort");

        run_sweep(0, 1'b1); check_results("ignored_start");
        run_sweep(0, 1'b0); check_results("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
